// File: rtl/alu_cmd_sequencer_if.sv
// Handshake bundle between the command sequencer, its producer/consumer and ALU_8_Bit.
// The sequencer takes the slave view; the environment driving it takes the master view.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [SEL_W-1:0] cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;
    logic             acc_clr;
    logic             sweep_start;
    logic             sweep_busy;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;
    logic [SEL_W-1:0] res_sel;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, acc_clr, sweep_start,
               alu_out, alu_carry, res_ready,
        output cmd_ready, sweep_busy, alu_a, alu_b, alu_sel,
               res_valid, res_data, res_carry, res_zero, res_sel, op_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, acc_clr, sweep_start,
               alu_out, alu_carry, res_ready,
        input  cmd_ready, sweep_busy, alu_a, alu_b, alu_sel,
               res_valid, res_data, res_carry, res_zero, res_sel, op_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command stage for ALU_8_Bit: registers operands/opcode, waits one settle cycle,
// captures the result behind a valid/ready handshake, and can sweep all opcodes.
module alu_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    alu_cmd_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sweep_q, sweep_d;
    logic             rv_q, rv_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             rc_q, rc_d;
    logic             rz_q, rz_d;
    logic [SEL_W-1:0] rs_q, rs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            sweep_q <= 1'b0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
            rc_q    <= 1'b0;
            rz_q    <= 1'b0;
            rs_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            sweep_q <= sweep_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            rc_q    <= rc_d;
            rz_q    <= rz_d;
            rs_q    <= rs_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        sweep_d = sweep_q;
        rv_d    = rv_q;
        rd_d    = rd_q;
        rc_d    = rc_q;
        rz_d    = rz_q;
        rs_d    = rs_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.acc_clr) acc_d = '0;
                if (bus.sweep_start) begin
                    a_d     = bus.cmd_a;
                    b_d     = bus.cmd_b;
                    sel_d   = '0;
                    sweep_d = 1'b1;
                    state_d = EXEC;
                end else if (bus.cmd_valid) begin
                    // A clear in the accept cycle must already be visible to a chained op
                    a_d     = bus.cmd_use_acc ? (bus.acc_clr ? '0 : acc_q) : bus.cmd_a;
                    b_d     = bus.cmd_b;
                    sel_d   = bus.cmd_op;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rd_d    = bus.alu_out;
                rc_d    = bus.alu_carry;
                rz_d    = (bus.alu_out == '0);
                rs_d    = sel_q;
                acc_d   = bus.alu_out;
                rv_d    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    rv_d  = 1'b0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sweep_q && sel_q != SEL_MAX) begin
                        sel_d   = sel_q + SEL_W'(1);
                        state_d = EXEC;
                    end else begin
                        sweep_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.sweep_busy = sweep_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_sel    = sel_q;
    assign bus.res_valid  = rv_q;
    assign bus.res_data   = rd_q;
    assign bus.res_carry  = rc_q;
    assign bus.res_zero   = rz_q;
    assign bus.res_sel    = rs_q;
    assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU_8_Bit, a transaction-level result
// model with a per-cycle compare, directed scenarios and a randomized tail.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH(8), .SEL_W(4), .CNT_W(8)) bus ();

    alu_cmd_sequencer #(.WIDTH(8), .SEL_W(4), .CNT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit rr_rand = 1'b0;

    // ALU_8_Bit behaviour: CarryOut is always the carry of A+B
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        logic [8:0] t;
        logic [7:0] r;
        t = {1'b0, a} + {1'b0, b};
        case (s)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a * b;
            4'd3:  r = (b == 8'd0) ? 8'd0 : a / b;
            4'd4:  r = a << 1;
            4'd5:  r = a >> 1;
            4'd6:  r = {a[6:0], a[7]};
            4'd7:  r = {a[0], a[7:1]};
            4'd8:  r = a & b;
            4'd9:  r = a | b;
            4'd10: r = a ^ b;
            4'd11: r = ~(a | b);
            4'd12: r = ~(a & b);
            4'd13: r = ~(a ^ b);
            4'd14: r = (a > b) ? 8'd1 : 8'd0;
            default: r = (a == b) ? 8'd1 : 8'd0;
        endcase
        return {t[8], r};
    endfunction

    always_comb {bus.alu_carry, bus.alu_out} = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: every accepted command or sweep becomes queued expected results
    typedef struct {
        logic [7:0] a, b;
        logic [3:0] sel;
        logic [7:0] d;
        logic       c;
    } exp_t;

    exp_t q[$];
    bit pend_m = 0, rv_m = 0, sw_m = 0;
    logic [7:0] acc_m = 0, cnt_m = 0;

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        exp_t e;
        logic [8:0] r;
        r = alu_f(a, b, s);
        e.a = a; e.b = b; e.sel = s; e.d = r[7:0]; e.c = r[8];
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            pend_m = 0; rv_m = 0; sw_m = 0; acc_m = 0; cnt_m = 0;
        end else if (q.size() == 0) begin
            if (bus.acc_clr) acc_m = 8'd0;
            if (bus.sweep_start) begin
                for (int s = 0; s < 16; s++) q.push_back(mk(bus.cmd_a, bus.cmd_b, 4'(s)));
                sw_m = 1; pend_m = 1;
            end else if (bus.cmd_valid) begin
                q.push_back(mk(bus.cmd_use_acc ? acc_m : bus.cmd_a, bus.cmd_b, bus.cmd_op));
                pend_m = 1;
            end
        end else if (pend_m) begin
            pend_m = 0; rv_m = 1; acc_m = q[0].d;
        end else if (rv_m && bus.res_ready) begin
            void'(q.pop_front());
            cnt_m = cnt_m + 8'd1; rv_m = 0;
            if (q.size() > 0) pend_m = 1;
            else sw_m = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
                chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
                chk("rst_res_data", 32'(bus.res_data), 32'd0);
                chk("rst_op_count", 32'(bus.op_count), 32'd0);
                chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
            end else begin
                chk("cmd_ready", 32'(bus.cmd_ready), 32'(q.size() == 0));
                chk("res_valid", 32'(bus.res_valid), 32'(rv_m));
                chk("sweep_busy", 32'(bus.sweep_busy), 32'(sw_m));
                chk("op_count", 32'(bus.op_count), 32'(cnt_m));
                if (q.size() > 0) begin
                    chk("alu_a", 32'(bus.alu_a), 32'(q[0].a));
                    chk("alu_b", 32'(bus.alu_b), 32'(q[0].b));
                    chk("alu_sel", 32'(bus.alu_sel), 32'(q[0].sel));
                end
                if (rv_m && q.size() > 0) begin
                    chk("res_data", 32'(bus.res_data), 32'(q[0].d));
                    chk("res_carry", 32'(bus.res_carry), 32'(q[0].c));
                    chk("res_zero", 32'(bus.res_zero), 32'(q[0].d == 8'd0));
                    chk("res_sel", 32'(bus.res_sel), 32'(q[0].sel));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.cmd_ready && n < 300) begin tick(); n++; end
        if (!bus.cmd_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rv(input string nm);
        int n = 0;
        while (!bus.res_valid && n < 100) begin tick(); n++; end
        if (!bus.res_valid) chk(nm, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic ua, input logic clr);
        wait_idle();
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op;
        bus.cmd_use_acc = ua; bus.acc_clr = clr; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0; bus.cmd_use_acc = 1'b0; bus.acc_clr = 1'b0;
    endtask

    task automatic sweep(input logic [7:0] a, input logic [7:0] b);
        wait_idle();
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = 4'($urandom);
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.sweep_start = 1'b1;
        tick();
        bus.sweep_start = 1'b0; bus.cmd_valid = 1'b0;
    endtask

    task automatic hs();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_now_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_now_sweep_busy", 32'(bus.sweep_busy), 32'd0);
        chk("rst_now_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_now_alu_b", 32'(bus.alu_b), 32'd0);
        chk("rst_now_res_sel", 32'(bus.res_sel), 32'd0);
        chk("rst_now_res_zero", 32'(bus.res_zero), 32'd0);
        chk("rst_now_res_carry", 32'(bus.res_carry), 32'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_a = 0; bus.cmd_b = 0;
        bus.cmd_use_acc = 0; bus.acc_clr = 0; bus.sweep_start = 0; bus.res_ready = 0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();

        // 1: single add, two-cycle latency from presenting the command
        send(8'hAA, 8'h55, 4'd0, 1'b0, 1'b0);
        chk("t1_early_valid", 32'(bus.res_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(bus.res_valid), 32'd1);
        chk("t1_data", 32'(bus.res_data), 32'hFF);
        chk("t1_carry", 32'(bus.res_carry), 32'd0);
        chk("t1_zero", 32'(bus.res_zero), 32'd0);
        chk("t1_sel", 32'(bus.res_sel), 32'd0);
        hs();
        chk("t1_count", 32'(bus.op_count), 32'd1);

        // 2: accumulate chain
        do_reset();
        send(8'h80, 8'h80, 4'd0, 1'b0, 1'b0);
        wait_rv("t2a_timeout");
        chk("t2a_data", 32'(bus.res_data), 32'h00);
        chk("t2a_carry", 32'(bus.res_carry), 32'd1);
        chk("t2a_zero", 32'(bus.res_zero), 32'd1);
        hs();
        send(8'h77, 8'h01, 4'd0, 1'b1, 1'b0);
        wait_rv("t2b_timeout");
        chk("t2b_data", 32'(bus.res_data), 32'h01);
        chk("t2b_carry", 32'(bus.res_carry), 32'd0);
        hs();
        chk("t2_count", 32'(bus.op_count), 32'd2);

        // 3: backpressure holds the result and blocks new commands
        send(8'h12, 8'h34, 4'd0, 1'b0, 1'b0);
        wait_rv("t3_timeout");
        bus.cmd_valid = 1'b1; bus.cmd_a = 8'hFF; bus.cmd_b = 8'h01; bus.cmd_op = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("t3_hold_data", 32'(bus.res_data), 32'h46);
        end
        bus.cmd_valid = 1'b0;
        hs();
        chk("t3_released", 32'(bus.res_valid), 32'd0);
        tick(); tick();
        chk("t3_count", 32'(bus.op_count), 32'd3);

        // 4: full opcode sweep with consumer always ready
        bus.res_ready = 1'b1;
        sweep(8'hAA, 8'h55);
        for (int i = 0; i < 16; i++) begin
            wait_rv("t4_timeout");
            chk("t4_sel", 32'(bus.res_sel), 32'(i));
            if (i == 0) chk("t4_add", 32'(bus.res_data), 32'hFF);
            if (i == 1) chk("t4_sub", 32'(bus.res_data), 32'h55);
            if (i == 8) chk("t4_and", 32'(bus.res_data), 32'h00);
            if (i == 15) chk("t4_eq", 32'(bus.res_data), 32'h00);
            if (i < 15) chk("t4_busy", 32'(bus.sweep_busy), 32'd1);
            tick();
        end
        bus.res_ready = 1'b0;
        chk("t4_busy_end", 32'(bus.sweep_busy), 32'd0);
        chk("t4_count", 32'(bus.op_count), 32'd19);

        // 5: reset in the middle of a sweep
        sweep(8'hAA, 8'h55);
        for (int i = 0; i < 5; i++) begin wait_rv("t5_timeout"); hs(); end
        wait_rv("t5_timeout5");
        chk("t5_sel", 32'(bus.res_sel), 32'd5);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("t5_ready", 32'(bus.cmd_ready), 32'd1);
            chk("t5_no_valid", 32'(bus.res_valid), 32'd0);
            tick();
        end

        // 6: clear-and-chain in one cycle, then counter wrap
        send(8'h99, 8'h33, 4'd0, 1'b1, 1'b1);
        wait_rv("t6_timeout");
        chk("t6_data", 32'(bus.res_data), 32'h33);
        hs();
        rr_rand = 1'b1;
        for (int i = 0; i < 255; i++)
            send(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
        wait_idle();
        chk("t6_wrap", 32'(bus.op_count), 32'd0);

        // random tail mixing sweeps and commands
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) sweep(8'($urandom), 8'($urandom));
            else send(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0));
        end
        wait_idle();
        rr_rand = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
